// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared loader state encoding and instruction-memory widths
package pipeline_pkg;
  localparam int IMEM_WORD_W = 16;
  localparam int IMEM_ADDR_W = 16;
  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, DONE
  } ld_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream, memory write port and CPU status of the loader
interface imem_loader_if;
  import pipeline_pkg::*;
  logic                   start;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   wr_en;
  logic [IMEM_ADDR_W-1:0] wr_addr;
  logic [IMEM_WORD_W-1:0] wr_data;
  logic                   cpu_hold;
  logic                   done;
  logic                   error;
  modport master (output start, byte_in, byte_valid,
                  input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
  modport slave  (input  start, byte_in, byte_valid,
                  output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
endinterface

// File: rtl/imem_ld_checksum.sv
// imem_ld_checksum: modulo-2^16 running sum of the words written by a load
module imem_ld_checksum
  import pipeline_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   add,
  input  logic [IMEM_WORD_W-1:0] word,
  output logic [IMEM_WORD_W-1:0] sum
);
  logic [IMEM_WORD_W-1:0] sum_q, sum_d;
  always_comb sum_d = clr ? '0 : add ? sum_q + word : sum_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  assign sum = sum_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: serial byte-stream loader into instruction memory, holds the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to require and verify a 16-bit sum trailer after the words.
module imem_loader
  import pipeline_pkg::*;
#(
  parameter int N = 16
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam logic [15:0] MAX_W = 16'(N / 2);
  ld_state_e state_q, state_d;
  logic [15:0] count_q, count_d, index_q, index_d, data_q, data_d, cnt_in;
  logic error_q, error_d, fire, start_ok;
  assign fire     = bus.byte_valid && bus.byte_ready;
  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);
  assign cnt_in   = {count_q[15:8], bus.byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_e TAIL = CHK_HI;
  logic [7:0]  chk_hi_q, chk_hi_d;
  logic [15:0] sum;
  imem_ld_checksum u_sum (.clk(clk), .rst(rst), .clr(start_ok), .add(bus.wr_en),
                          .word(bus.wr_data), .sum(sum));
`else
  localparam ld_state_e TAIL = DONE;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    data_d  = data_q;
    error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_hi_d = chk_hi_q;
`endif
    case (state_q)
      IDLE, DONE: if (start_ok) begin state_d = CNT_HI; error_d = 1'b0; index_d = '0; end
      CNT_HI: if (fire) begin count_d[15:8] = bus.byte_in; state_d = CNT_LO; end
      CNT_LO: if (fire) begin
        count_d = cnt_in;
        error_d = cnt_in > MAX_W;
        state_d = cnt_in > MAX_W ? DONE : cnt_in == '0 ? TAIL : DAT_HI;
      end
      DAT_HI: if (fire) begin data_d[15:8] = bus.byte_in; state_d = DAT_LO; end
      DAT_LO: if (fire) begin data_d[7:0] = bus.byte_in; state_d = WRITE; end
      WRITE: begin
        index_d = index_q + 16'd1;
        state_d = index_d == count_q ? TAIL : DAT_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK_HI: if (fire) begin chk_hi_d = bus.byte_in; state_d = CHK_LO; end
      CHK_LO: if (fire) begin error_d = {chk_hi_q, bus.byte_in} != sum; state_d = DONE; end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) chk_hi_q <= '0;
    else      chk_hi_q <= chk_hi_d;
`endif
  // Every output is decoded from the registered state so reset clears them at once.
  assign bus.byte_ready = state_q inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO};
  assign bus.wr_en      = state_q == WRITE;
  assign bus.wr_addr    = bus.wr_en ? (index_q << 1) : '0;
  assign bus.wr_data    = bus.wr_en ? data_q : '0;
  assign bus.cpu_hold   = state_q != DONE;
  assign bus.done       = state_q == DONE;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard checked by an independent monitor
module tb_imem_loader;
  import pipeline_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int nwr = 0;
  logic [31:0] sb[$];
  logic [15:0] wtab [8];
  imem_loader_if bus();
  imem_loader #(.N(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst && bus.wr_en) begin
      logic [31:0] e;
      nwr++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h/%h exp=none", bus.wr_addr, bus.wr_data);
      end else begin
        e = sb.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          bad++;
          $display("FAIL write got=%h/%h exp=%h/%h", bus.wr_addr, bus.wr_data, e[31:16], e[15:0]);
        end
      end
    end else if (rst) begin
      total++;
      if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
        bad++;
        $display("FAIL idle_bus got=%h/%h exp=0/0", bus.wr_addr, bus.wr_data);
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'hEE;
      @(posedge clk); #1;
    end
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.byte_ready;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=ready0 exp=ready1 byte=%h", b);
    end
  endtask

  task automatic load(input logic [15:0] cnt, input int n, input bit gap, input bit mid_start,
                      input logic [15:0] delta);
    logic [15:0] sum = '0;
    nwr = 0;
    pulse_start();
    send(cnt[15:8], gap);
    send(cnt[7:0], gap);
    if (mid_start) begin
      pulse_start();
      chk("mid_start_state", 32'(dut.state_q), 32'(DAT_HI));
    end
    for (int i = 0; i < n; i++) begin
      sb.push_back({16'(2 * i), wtab[i]});
      sum = sum + wtab[i];
      send(wtab[i][15:8], gap);
      send(wtab[i][7:0], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (cnt <= 16'd8) begin
      sum = sum + delta;
      send(sum[15:8], gap);
      send(sum[7:0], gap);
    end
`endif
  endtask

  task automatic finish_load(input string name, input bit exp_err, input int exp_wr);
    for (int i = 0; i < 50 && !bus.done; i++) @(negedge clk);
    chk({name, "_done"}, 32'(bus.done), 1);
    chk({name, "_hold"}, 32'(bus.cpu_hold), 0);
    chk({name, "_error"}, 32'(bus.error), 32'(exp_err));
    chk({name, "_writes"}, nwr, exp_wr);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_state"}, 32'(dut.state_q), 32'(IDLE));
    chk({name, "_index"}, 32'(dut.index_q), 0);
    chk({name, "_count"}, 32'(dut.count_q), 0);
    chk({name, "_outs"}, {bus.wr_en, bus.byte_ready, bus.done, bus.error, bus.cpu_hold}, 32'b00001);
    chk({name, "_addr_data"}, {bus.wr_addr, bus.wr_data}, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b1;
    @(posedge clk); #1;

    wtab[0] = 16'h1010; wtab[1] = 16'h1011;
    load(16'h0002, 2, 1'b0, 1'b0, 16'h0);
    finish_load("basic", 1'b0, 2);

    load(16'h0009, 0, 1'b0, 1'b0, 16'h0);
    finish_load("oversize", 1'b1, 0);

    load(16'h0000, 0, 1'b0, 1'b0, 16'h0);
    finish_load("zero", 1'b0, 0);

    wtab[0] = 16'hA1B2; wtab[1] = 16'hC3D4; wtab[2] = 16'h00FF; wtab[3] = 16'hFF00;
    load(16'h0004, 4, 1'b1, 1'b0, 16'h0);
    finish_load("gapped", 1'b0, 4);

    for (int i = 0; i < 8; i++) wtab[i] = 16'(16'h0101 * (i + 1));
    load(16'h0008, 8, 1'b0, 1'b0, 16'h0);
    finish_load("max", 1'b0, 8);

    wtab[0] = 16'h1234; wtab[1] = 16'h5678; wtab[2] = 16'h9ABC;
    load(16'h0003, 3, 1'b0, 1'b1, 16'h0);
    finish_load("mid_start", 1'b0, 3);

    nwr = 0;
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    sb.push_back({16'h0000, 16'h1010});
    send(8'h10, 1'b0);
    send(8'h10, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_writes", nwr, 1);
    rst = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wtab[0] = 16'hBEEF; wtab[1] = 16'hCAFE;
    load(16'h0002, 2, 1'b0, 1'b0, 16'h0);
    finish_load("after_rst", 1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wtab[0] = 16'h1010; wtab[1] = 16'h1000;
    load(16'h0002, 2, 1'b0, 1'b0, 16'h0);
    finish_load("chk_good", 1'b0, 2);
    load(16'h0002, 2, 1'b0, 1'b0, 16'h1);
    finish_load("chk_bad", 1'b1, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter N, default 16: instruction memory entry count; words are stored at even addresses, so the maximum load is N/2 words.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-005 SHALL have port byte_in, input, 8 bits: serial program byte.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-007 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port wr_en, output, 1 bit: instruction memory write strobe.
REQ-009 SHALL have port wr_addr, output, 16 bits: memory write address.
REQ-010 SHALL have port wr_data, output, 16 bits: instruction word to write.
REQ-011 SHALL have port cpu_hold, output, 1 bit: holds the fetch stage and pipeline until the load completes.
REQ-012 SHALL have port done, output, 1 bit: load finished (level).
REQ-013 SHALL have port error, output, 1 bit: oversize count or checksum mismatch (level).

Function
REQ-014 SHALL transfer a byte only in a cycle where byte_valid && byte_ready.
REQ-015 SHALL implement the states IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO and DONE.
REQ-016 SHALL assert byte_ready only in CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK_HI and CHK_LO.
REQ-017 SHALL move IDLE->CNT_HI on start, and DONE->CNT_HI on start (reload); start SHALL be ignored in every other state.
REQ-018 SHALL receive the stream as: 16-bit word count (high byte first), then count words (each high byte first).
REQ-019 SHALL go CNT_LO->DONE with no writes when count == 0.
REQ-020 SHALL go CNT_LO->DONE with no writes and set error=1 when count > N/2.
REQ-021 SHALL go DAT_LO->WRITE after the low byte is accepted; WRITE SHALL last exactly one cycle with wr_en=1, wr_addr = 2*index, wr_data = {hi,lo}.
REQ-022 SHALL increment index after WRITE; when index == count the next state SHALL be DONE (or CHK_HI, see REQ-029), otherwise DAT_HI.
REQ-023 SHALL deliver the first word at address 0, with one write per 2 accepted bytes plus 1 cycle; wr_en latency is 1 cycle after the low-byte handshake.
REQ-024 SHALL drive cpu_hold=1 in every state except DONE, and done=1 only in DONE.
REQ-025 SHALL clear error on every accepted start.
REQ-026 SHALL drive wr_addr and wr_data to 0 whenever wr_en=0.

Reset
REQ-027 SHALL, while rst=0 and regardless of the current state (including mid-load), immediately force state=IDLE, index=0, count=0, wr_en=0, wr_addr=0, wr_data=0, byte_ready=0, done=0, error=0 and cpu_hold=1.
REQ-028 SHALL NOT undo or clear memory words already written before a mid-load reset.

Configuration
REQ-029 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, accumulate a modulo-2^16 sum of all written words, go WRITE->CHK_HI after the last word (and CNT_LO->CHK_HI when count == 0), accept a 16-bit trailer (high byte first) in CHK_HI/CHK_LO, then enter DONE with error=1 if trailer != sum.
REQ-030 SHALL, without IMEM_LOADER_CHECKSUM_EN, never enter the CHK states and raise error only for an oversize count.

Structure
REQ-031 SHALL take the state enumeration, IMEM_WORD_W=16 and IMEM_ADDR_W=16 from the shared package pipeline_pkg.
REQ-032 SHALL place the checksum accumulator in the sub-module imem_ld_checksum, instantiated only under IMEM_LOADER_CHECKSUM_EN.

Verification
REQ-033 SHALL verify: start, bytes 00 02 10 10 10 11 with byte_valid held high -> writes (0,1010), (2,1011); done=1; cpu_hold=0; error=0.
REQ-034 SHALL verify: count 0009 with N=16 -> no wr_en, done=1, error=1.
REQ-035 SHALL verify: byte_valid toggled every other cycle during a 4-word load -> exactly 4 writes at addresses 0,2,4,6 with correct data.
REQ-036 SHALL verify: rst pulsed low after the first WRITE -> all outputs at reset values, state IDLE, cpu_hold=1; a new load then completes normally.
REQ-037 SHALL verify, under IMEM_LOADER_CHECKSUM_EN: words 1010, 1000 with trailer 2010 -> error=0; with trailer 2011 -> error=1.
REQ-038 SHALL verify: start pulsed while in DAT_HI -> ignored, load continues unchanged.
